// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//   Sequences a synchronous instruction ROM (1-cycle read latency). It owns
//   the program counter, issues at most one read per cycle, buffers the
//   returned words in a 2-entry FIFO and presents them downstream with a
//   valid/ready handshake. Each word is tagged with its fetch address.
//   The block handles start, jumps (which flush all buffered and in-flight
//   words) and stops fetching once a HALT_OP word has been buffered.
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        asynchronous, active-high reset
//   start_i        pulse, IDLE -> RUN (ignored in other states)
//   jump_en_i      pulse, flush and redirect PC to jump_addr_i, enter RUN
//   jump_addr_i    jump target
//   rom_addr_o     ROM read address (the PC register)
//   rom_en_o       ROM read strobe (combinational issue decision)
//   rom_data_i     ROM word for the address issued in the previous cycle
//   instr_o        FIFO head word
//   instr_pc_o     address of the FIFO head word
//   instr_valid_o  FIFO head is valid
//   instr_ready_i  downstream accepts the head word
//   halted_o       high while in HALTED state
// ---------------------------------------------------------------------------
module fetch_controller #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 24,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OP  = 6'h3F
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               jump_en_i,
    input  logic [ADDR_W-1:0]  jump_addr_i,
    output logic [ADDR_W-1:0]  rom_addr_o,
    output logic               rom_en_o,
    input  logic [INSTR_W-1:0] rom_data_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic               halted_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Opcode field lives in the top six bits of the instruction word.
    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return (word[INSTR_W-1 -: 6] == HALT_OP);
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                inflight_q, inflight_d;
    logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic [1:0]          occ_q, occ_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [INSTR_W-1:0]  fifo_data_q [2];
    logic [ADDR_W-1:0]   fifo_pc_q   [2];

    logic                pop_s;
    logic                push_s;
    logic                issue_s;
    logic [2:0]          demand_s;

    // Handshake, issue and return-path decisions for the current cycle.
    always_comb begin
        pop_s    = (occ_q != 2'd0) && instr_ready_i;
        // Slots that will be committed after this edge if nothing new issues;
        // a pop this cycle frees a slot for the next read immediately.
        demand_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s  = (state_q == S_RUN) && !jump_en_i && (demand_s < 3'd2);
        // Returning data is discarded on a jump, and once HALTED a word that
        // was issued behind the HALT word is never buffered.
        push_s   = inflight_q && !jump_en_i && (state_q != S_HALTED);
    end

    // Next-state logic for the FSM, PC, in-flight tracking and FIFO pointers.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        occ_d         = occ_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (jump_en_i) begin
            // A same-cycle pop is simply absorbed by the flush.
            state_d  = S_RUN;
            pc_d     = jump_addr_i;
            occ_d    = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (push_s && is_halt(rom_data_i)) begin
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_HALTED: begin
                    state_d = S_HALTED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (issue_s) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + PC_ONE;
            end else begin
                inflight_d    = 1'b0;
            end

            occ_d    = occ_q + {1'b0, push_s} - {1'b0, pop_s};
            wr_ptr_d = wr_ptr_q ^ push_s;
            rd_ptr_d = rd_ptr_q ^ pop_s;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            occ_q         <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            occ_q         <= occ_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_pc_q[0]   <= '0;
            fifo_pc_q[1]   <= '0;
        end else if (push_s) begin
            fifo_data_q[wr_ptr_q] <= rom_data_i;
            fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
        end else begin
            fifo_data_q[wr_ptr_q] <= fifo_data_q[wr_ptr_q];
            fifo_pc_q[wr_ptr_q]   <= fifo_pc_q[wr_ptr_q];
        end
    end

    assign rom_addr_o    = pc_q;
    assign rom_en_o      = issue_s;
    assign instr_o       = fifo_data_q[rd_ptr_q];
    assign instr_pc_o    = fifo_pc_q[rd_ptr_q];
    assign instr_valid_o = (occ_q != 2'd0);
    assign halted_o      = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
//   Scoreboard bench: stimulus pushes the expected {pc, word} stream into a
//   queue, a negedge monitor pops and compares every accepted word.
//   A second instance with ADDR_W = 4 covers PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_controller;

    localparam logic [23:0] HALT_W = 24'hFC0000;

    typedef struct packed {
        logic [7:0]  pc;
        logic [23:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, jump_en, instr_ready;
    logic [7:0]  jump_addr;
    logic [7:0]  rom_addr, instr_pc;
    logic        rom_en, instr_valid, halted;
    logic [23:0] rom_data = 24'h0;
    logic [23:0] instr;
    logic [23:0] rom [256];

    logic        start4, jump4, instr_ready4;
    logic [3:0]  jump_addr4, rom_addr4, instr_pc4;
    logic        rom_en4, instr_valid4, halted4;
    logic [23:0] rom_data4 = 24'h0;
    logic [23:0] instr4;
    logic [23:0] rom4 [16];

    exp_t q  [$];
    exp_t q4 [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fetch_controller #(.ADDR_W(8), .INSTR_W(24), .RESET_PC(8'h00), .HALT_OP(6'h3F)) u_dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .jump_en_i(jump_en),
        .jump_addr_i(jump_addr), .rom_addr_o(rom_addr), .rom_en_o(rom_en),
        .rom_data_i(rom_data), .instr_o(instr), .instr_pc_o(instr_pc),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready), .halted_o(halted)
    );

    fetch_controller #(.ADDR_W(4), .INSTR_W(24), .RESET_PC(4'd14), .HALT_OP(6'h3F)) u_dut4 (
        .clk_i(clk), .reset_i(reset), .start_i(start4), .jump_en_i(jump4),
        .jump_addr_i(jump_addr4), .rom_addr_o(rom_addr4), .rom_en_o(rom_en4),
        .rom_data_i(rom_data4), .instr_o(instr4), .instr_pc_o(instr_pc4),
        .instr_valid_o(instr_valid4), .instr_ready_i(instr_ready4), .halted_o(halted4)
    );

    // Synchronous ROM models, one-cycle read latency.
    always @(posedge clk) begin
        if (rom_en)  rom_data  <= rom[rom_addr];
        if (rom_en4) rom_data4 <= rom4[rom_addr4];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted word must match the head of its queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && instr_valid && instr_ready) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %0h data %0h, expected no word", instr_pc, instr);
            end else begin
                e = q.pop_front();
                chk("sb_pc", 32'(instr_pc), 32'(e.pc));
                chk("sb_data", 32'(instr), 32'(e.data));
            end
        end
        if (!reset && instr_valid4 && instr_ready4) begin
            if (q4.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb4_unexpected: got pc %0h data %0h, expected no word", instr_pc4, instr4);
            end else begin
                e = q4.pop_front();
                chk("sb4_pc", 32'({4'h0, instr_pc4}), 32'(e.pc));
                chk("sb4_data", 32'(instr4), 32'(e.data));
            end
        end
    end

    task automatic push_range(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            e.pc   = 8'(i);
            e.data = rom[i];
            q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (q.size() == 0 && q4.size() == 0) break;
        end
        chk(name, 32'(q.size() + q4.size()), 32'd0);
    endtask

    task automatic wait_head(input string name, input logic [7:0] pc, input int max);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (instr_valid && instr_pc == pc) begin
                found = 1'b1;
                break;
            end
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic jump_pulse(input logic [7:0] addr);
        @(posedge clk); #1;
        jump_addr = addr;
        jump_en   = 1'b1;
        @(posedge clk); #1;
        jump_en   = 1'b0;
    endtask

    initial begin : stim
        exp_t e;
        reset = 1'b1; start = 1'b0; jump_en = 1'b0; jump_addr = 8'h00; instr_ready = 1'b1;
        start4 = 1'b0; jump4 = 1'b0; jump_addr4 = 4'h0; instr_ready4 = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 24'h100000 + 24'(i);
        rom[20]    = HALT_W;
        rom[8'h44] = HALT_W;
        for (int i = 0; i < 16; i++) rom4[i] = 24'h100000 + 24'(i);
        rom4[1] = HALT_W;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h00);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_instr_pc", 32'(instr_pc), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst4_rom_addr", 32'(rom_addr4), 32'd14);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_fetch", 32'(rom_en), 32'd0);

        // Test 1: start, first word two edges later, one word per cycle
        push_range(0, 20);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("t1_valid_n0", 32'(instr_valid), 32'd0);
        chk("t1_rom_en_n0", 32'(rom_en), 32'd1);
        chk("t1_rom_addr_n0", 32'(rom_addr), 32'h00);
        @(negedge clk);
        chk("t1_valid_n1", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_n2", 32'(instr_valid), 32'd1);
        chk("t1_pc_n2", 32'(instr_pc), 32'h00);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("t1_stream_valid", 32'(instr_valid), 32'd1);
            chk("t1_stream_pc", 32'(instr_pc), 32'(k));
        end

        // Test 2: backpressure for five cycles, head frozen, issue stopped
        @(posedge clk); #1 instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_frozen_valid", 32'(instr_valid), 32'd1);
            chk("t2_frozen_pc", 32'(instr_pc), 32'h06);
            chk("t2_frozen_data", 32'(instr), 32'h100006);
            chk("t2_rom_en_low", 32'(rom_en), 32'd0);
        end
        @(posedge clk); #1 instr_ready = 1'b1;
        wait_drain("t2_drain", 80);
        @(negedge clk);
        chk("t2_halted", 32'(halted), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_halt_rom_en", 32'(rom_en), 32'd0);
            chk("t2_halt_valid", 32'(instr_valid), 32'd0);
        end

        // Test 3: leave HALTED by jump, then jump to 0x40 mid-stream
        push_range(8'h30, 8'h33);
        push_range(8'h40, 8'h44);
        jump_pulse(8'h30);
        @(negedge clk);
        chk("t3_unhalted", 32'(halted), 32'd0);
        wait_head("t3_reach_33", 8'h33, 20);
        jump_addr = 8'h40;
        jump_en   = 1'b1;
        @(posedge clk); #1 jump_en = 1'b0;
        @(negedge clk);
        chk("t3_flush_valid0", 32'(instr_valid), 32'd0);
        chk("t3_rom_addr", 32'(rom_addr), 32'h40);
        @(negedge clk);
        chk("t3_flush_valid1", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("t3_new_valid", 32'(instr_valid), 32'd1);
        chk("t3_new_pc", 32'(instr_pc), 32'h40);
        wait_drain("t3_drain", 40);

        // Test 4: HALT word at address 5
        rom[5] = {6'h3F, 18'h0};
        push_range(0, 5);
        jump_pulse(8'h00);
        @(negedge clk);
        chk("t4_unhalted", 32'(halted), 32'd0);
        wait_drain("t4_drain", 40);
        @(negedge clk);
        chk("t4_halted", 32'(halted), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_rom_en_low", 32'(rom_en), 32'd0);
        end
        rom[5] = 24'h100005;

        // Test 5: 4-bit PC wraps 14, 15, 0, 1 (HALT at 1)
        for (int i = 0; i < 4; i++) begin
            e.pc   = 8'((14 + i) % 16);
            e.data = rom4[(14 + i) % 16];
            q4.push_back(e);
        end
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        wait_drain("t5_drain", 40);
        @(negedge clk);
        chk("t5_halted", 32'(halted4), 32'd1);
        chk("t5_valid", 32'(instr_valid4), 32'd0);

        // Test 6: asynchronous reset while a word is valid
        push_range(0, 2);
        jump_pulse(8'h00);
        wait_head("t6_reach_2", 8'h02, 20);
        #2 reset = 1'b1;
        #1;
        chk("t6_valid_drop", 32'(instr_valid), 32'd0);
        chk("t6_rom_en_drop", 32'(rom_en), 32'd0);
        chk("t6_pc_reset", 32'(rom_addr), 32'h00);
        chk("t6_halted", 32'(halted), 32'd0);
        chk("t6_sb_empty", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t6_no_fetch", 32'(rom_en), 32'd0);
            chk("t6_no_valid", 32'(instr_valid), 32'd0);
        end

        chk("end_sb_empty", 32'(q.size() + q4.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
